// File: rtl/adc5g_ps_sequencer.sv
// -----------------------------------------------------------------------------
// adc5g_ps_sequencer
//
// Drives the dynamic phase-shift interface of one ADC5G capture MMCM on behalf
// of the OPB controller registers. Software posts a direction plus a step count.
// The sequencer then issues one PSEN pulse per step and waits for PSDONE, with
// a timeout. It keeps a running signed phase position and reports busy, done
// and error status.
//
// Ports:
//   OPB_Clk      sole clock (also the MMCM PSCLK at top level)
//   OPB_Rst      asynchronous active-high reset
//   cmd_valid    command request
//   cmd_ready    command can be accepted (idle and MMCM locked)
//   cmd_dir      1 = increment, 0 = decrement
//   cmd_steps    number of phase-shift steps
//   clear_pos    synchronous clear of phase_pos
//   dcm_locked   MMCM lock status
//   psen         MMCM phase-shift enable, one cycle per step
//   psincdec     MMCM phase-shift direction, held from accept to next accept
//   psdone       MMCM phase-shift completion
//   busy         command in progress
//   done         one-cycle pulse at command end (success or error)
//   steps_done   steps completed in current or last command
//   phase_pos    accumulated position, two's complement, wraps mod 2^POS_W
//   err_timeout  sticky: PSDONE did not arrive in time
//   err_lock     sticky: command aborted on lock loss
// -----------------------------------------------------------------------------
module adc5g_ps_sequencer #(
   parameter int STEP_W         = 10,
   parameter int POS_W          = 16,
   parameter int TIMEOUT_CYCLES = 1024,
   parameter int GAP_CYCLES     = 2
) (
   input  logic              OPB_Clk,
   input  logic              OPB_Rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_dir,
   input  logic [STEP_W-1:0] cmd_steps,
   input  logic              clear_pos,
   input  logic              dcm_locked,
   output logic              psen,
   output logic              psincdec,
   input  logic              psdone,
   output logic              busy,
   output logic              done,
   output logic [STEP_W-1:0] steps_done,
   output logic [POS_W-1:0]  phase_pos,
   output logic              err_timeout,
   output logic              err_lock
);

   localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);
   localparam int GCNT_W = $clog2(GAP_CYCLES + 1);
   localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [GCNT_W-1:0] GCNT_LAST = GCNT_W'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, PULSE, WAIT, GAP, FIN} state_t;

   state_t            state, next_state;
   logic [STEP_W-1:0] remaining;
   logic [TCNT_W-1:0] tcnt;
   logic [GCNT_W-1:0] gcnt;
   logic              accept, step_ok, timeout_hit, lock_lost;

   // Decoded straight from the state register: psen and busy drop as soon as
   // reset asserts, with no clock edge needed.
   assign cmd_ready = (state == IDLE) && dcm_locked;
   assign psen      = (state == PULSE);
   assign busy      = (state != IDLE);

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      next_state  = state;
      accept      = 1'b0;
      step_ok     = 1'b0;
      timeout_hit = 1'b0;
      lock_lost   = 1'b0;
      case (state)
         IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept     = 1'b1;
               next_state = (cmd_steps == '0) ? FIN : PULSE;
            end
         end
         PULSE: begin
            // The pulse already on psen still lasts its full single cycle.
            if (!dcm_locked) begin
               lock_lost  = 1'b1;
               next_state = FIN;
            end else begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            // Lock loss wins. A psdone in the expiry cycle still counts as a
            // completed step.
            if (!dcm_locked) begin
               lock_lost  = 1'b1;
               next_state = FIN;
            end else if (psdone) begin
               step_ok    = 1'b1;
               next_state = (remaining == STEP_W'(1)) ? FIN : GAP;
            end else if (tcnt == TCNT_LAST) begin
               timeout_hit = 1'b1;
               next_state  = FIN;
            end
         end
         GAP: begin
            if (!dcm_locked) begin
               lock_lost  = 1'b1;
               next_state = FIN;
            end else if (gcnt == GCNT_LAST) begin
               next_state = PULSE;
            end
         end
         FIN:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) state <= IDLE;
      else         state <= next_state;
   end

   always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
      if (OPB_Rst) begin
         done        <= 1'b0;
         psincdec    <= 1'b0;
         remaining   <= '0;
         steps_done  <= '0;
         phase_pos   <= '0;
         err_timeout <= 1'b0;
         err_lock    <= 1'b0;
         tcnt        <= '0;
         gcnt        <= '0;
      end else begin
         done <= (state == FIN);

         if (accept) begin
            psincdec    <= cmd_dir;
            remaining   <= cmd_steps;
            steps_done  <= '0;
            err_timeout <= 1'b0;
            err_lock    <= 1'b0;
         end

         // The timeout window restarts at every pulse. WAIT always exits by
         // TCNT_LAST, so the counter never needs to saturate.
         if (state == PULSE)     tcnt <= '0;
         else if (state == WAIT) tcnt <= tcnt + TCNT_W'(1);

         if (state == WAIT)     gcnt <= '0;
         else if (state == GAP) gcnt <= gcnt + GCNT_W'(1);

         if (step_ok) begin
            steps_done <= steps_done + STEP_W'(1);
            if (remaining != STEP_W'(1)) remaining <= remaining - STEP_W'(1);
         end

         if (timeout_hit) err_timeout <= 1'b1;
         if (lock_lost)   err_lock    <= 1'b1;

         // A software clear beats a same-cycle step update.
         if (clear_pos)    phase_pos <= '0;
         else if (step_ok) phase_pos <= psincdec ? phase_pos + POS_W'(1)
                                                 : phase_pos - POS_W'(1);
      end
   end

endmodule

// File: tb/tb_adc5g_ps_sequencer.sv
// -----------------------------------------------------------------------------
// tb_adc5g_ps_sequencer
//
// Directed bench for adc5g_ps_sequencer. A simple MMCM responder answers each
// psen with psdone a programmable number of cycles later. It can withhold one
// chosen pulse, and it tracks pulse width, psdone-to-psen spacing and the
// psincdec hold. All expected values are hand-derived cycle counts.
// -----------------------------------------------------------------------------
module tb_adc5g_ps_sequencer;

   localparam int STEP_W = 10;
   localparam int POS_W  = 16;
   localparam int TO     = 32;
   localparam int GAP    = 2;

   logic              OPB_Clk    = 1'b0;
   logic              OPB_Rst    = 1'b0;
   logic              cmd_valid  = 1'b0;
   logic              cmd_dir    = 1'b0;
   logic [STEP_W-1:0] cmd_steps  = '0;
   logic              clear_pos  = 1'b0;
   logic              dcm_locked = 1'b1;
   logic              psdone     = 1'b0;
   logic              cmd_ready, psen, psincdec, busy, done;
   logic              err_timeout, err_lock;
   logic [STEP_W-1:0] steps_done;
   logic [POS_W-1:0]  phase_pos;

   adc5g_ps_sequencer #(
      .STEP_W(STEP_W), .POS_W(POS_W), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
   ) dut (
      .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .cmd_valid(cmd_valid),
      .cmd_ready(cmd_ready), .cmd_dir(cmd_dir), .cmd_steps(cmd_steps),
      .clear_pos(clear_pos), .dcm_locked(dcm_locked), .psen(psen),
      .psincdec(psincdec), .psdone(psdone), .busy(busy), .done(done),
      .steps_done(steps_done), .phase_pos(phase_pos),
      .err_timeout(err_timeout), .err_lock(err_lock)
   );

   always #5 OPB_Clk = ~OPB_Clk;

   int   checks = 0, errors = 0;
   int   cyc = 0, psen_cnt = 0, drop_idx = -1, ps_delay = 12, countdown = 0;
   int   last_pd = -1000, last_psen_cyc = 0, min_gap = 1000;
   int   wide_cnt = 0, dir_bad = 0, acc_cyc = 0, done_at = 0, base = 0;
   bit   psen_prev = 1'b0;
   logic mon_dir = 1'b0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // MMCM responder and monitors, run 1 time unit after every rising edge.
   initial forever begin
      @(posedge OPB_Clk);
      #1;
      cyc++;
      if (countdown > 0) begin
         countdown--;
         psdone = (countdown == 0);
      end else begin
         psdone = 1'b0;
      end
      if (psdone) last_pd = cyc;
      if (psen) begin
         psen_cnt++;
         last_psen_cyc = cyc;
         if (cyc - last_pd < min_gap) min_gap = cyc - last_pd;
         if (psen_prev) wide_cnt++;
         if (psen_cnt != drop_idx) countdown = ps_delay;
      end
      psen_prev = psen;
      if (busy && psincdec !== mon_dir) dir_bad++;
   end

   // Main process acts 2 time units after each rising edge.
   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge OPB_Clk);
         #2;
      end
   endtask

   task automatic send(input logic dir, input int steps);
      int n = 0;
      while (!cmd_ready && n < 50) begin
         tick();
         n++;
      end
      check("ready_before_send", {31'd0, cmd_ready}, 1);
      mon_dir   = dir;
      cmd_valid = 1'b1;
      cmd_dir   = dir;
      cmd_steps = STEP_W'(steps);
      acc_cyc   = cyc;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      done_at = -1;
      while (n < max) begin
         tick();
         n++;
         if (done) begin
            done_at = cyc;
            break;
         end
      end
      check("done_seen", {31'd0, done}, 1);
   endtask

   initial begin
      // Reset state.
      #1 OPB_Rst = 1'b1;
      tick(2);
      check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
      check("rst_psen", {31'd0, psen}, 0);
      check("rst_busy", {31'd0, busy}, 0);
      check("rst_done", {31'd0, done}, 0);
      check("rst_phase", {16'd0, phase_pos}, 0);
      check("rst_errs", {30'd0, err_timeout, err_lock}, 0);
      OPB_Rst = 1'b0;
      tick();

      // Three increment steps, psdone 12 cycles after each psen.
      base = psen_cnt;
      send(1'b1, 3);
      check("t1_first_psen", {31'd0, psen}, 1);
      wait_done(200);
      check("t1_done_latency", done_at - acc_cyc, 45);
      check("t1_psen_count", psen_cnt - base, 3);
      check("t1_min_gap", min_gap, GAP + 1);
      check("t1_psen_width", wide_cnt, 0);
      check("t1_steps_done", steps_done, 3);
      check("t1_phase", phase_pos, 3);
      check("t1_psincdec", {31'd0, psincdec}, 1);
      check("t1_busy_at_done", {31'd0, busy}, 0);
      check("t1_errs", {30'd0, err_timeout, err_lock}, 0);
      tick();
      check("t1_done_one_cycle", {31'd0, done}, 0);

      // Decrement below zero, then increment back through the wrap.
      clear_pos = 1'b1;
      tick();
      clear_pos = 1'b0;
      check("t2_clear", phase_pos, 0);
      send(1'b0, 2);
      wait_done(200);
      check("t2_done_latency", done_at - acc_cyc, 30);
      check("t2_phase_neg", phase_pos, 32'h0000_FFFE);
      check("t2_psincdec", {31'd0, psincdec}, 0);
      send(1'b1, 2);
      wait_done(200);
      check("t2_phase_wrap", phase_pos, 0);
      check("t2_steps_done", steps_done, 2);

      // Zero-step command, plus a cmd_valid that arrives while busy.
      base = psen_cnt;
      send(1'b1, 0);
      check("t3_busy_fin", {31'd0, busy}, 1);
      check("t3_done_early", {31'd0, done}, 0);
      cmd_valid = 1'b1;
      cmd_steps = STEP_W'(3);
      tick();
      cmd_valid = 1'b0;
      check("t3_done_at_2", cyc - acc_cyc, 2);
      check("t3_done", {31'd0, done}, 1);
      check("t3_busy_ignore", {31'd0, busy}, 0);
      check("t3_steps_done", steps_done, 0);
      tick(2);
      check("t3_no_psen", psen_cnt - base, 0);

      // Timeout: the second psdone of five is withheld.
      base     = psen_cnt;
      drop_idx = psen_cnt + 2;
      send(1'b1, 5);
      wait_done(300);
      check("t4_timeout_latency", done_at - last_psen_cyc, TO + 2);
      check("t4_err_timeout", {31'd0, err_timeout}, 1);
      check("t4_err_lock", {31'd0, err_lock}, 0);
      check("t4_steps_done", steps_done, 1);
      check("t4_phase", phase_pos, 1);
      check("t4_psen_count", psen_cnt - base, 2);
      check("t4_cmd_ready", {31'd0, cmd_ready}, 1);
      send(1'b1, 0);
      check("t4_err_cleared", {31'd0, err_timeout}, 0);
      wait_done(20);

      // Lock loss in WAIT of step 1 of 4; its late psdone arrives while idle.
      ps_delay = 20;
      send(1'b0, 4);
      tick(3);
      dcm_locked = 1'b0;
      tick();
      check("t5_err_lock", {31'd0, err_lock}, 1);
      check("t5_busy_fin", {31'd0, busy}, 1);
      check("t5_ready_fin", {31'd0, cmd_ready}, 0);
      tick();
      check("t5_done", {31'd0, done}, 1);
      check("t5_busy_idle", {31'd0, busy}, 0);
      check("t5_ready_unlocked", {31'd0, cmd_ready}, 0);
      tick(18);
      check("t5_stray_phase", phase_pos, 1);
      check("t5_stray_steps", steps_done, 0);
      check("t5_psincdec", {31'd0, psincdec}, 0);
      dcm_locked = 1'b1;
      #1;
      check("t5_ready_relock", {31'd0, cmd_ready}, 1);
      ps_delay = 12;

      // clear_pos in the same cycle as psdone.
      send(1'b1, 1);
      tick(12);
      clear_pos = 1'b1;
      tick();
      clear_pos = 1'b0;
      check("t6_clear_wins", phase_pos, 0);
      check("t6_steps_done", steps_done, 1);
      wait_done(20);

      // Reset mid-WAIT, then reset during PULSE.
      send(1'b1, 1);
      wait_done(100);
      check("t7_phase_pre", phase_pos, 1);
      send(1'b1, 3);
      tick(3);
      OPB_Rst = 1'b1;
      #1;
      check("t7_rst_psen", {31'd0, psen}, 0);
      check("t7_rst_busy", {31'd0, busy}, 0);
      check("t7_rst_phase", phase_pos, 0);
      check("t7_rst_steps", steps_done, 0);
      OPB_Rst = 1'b0;
      tick();
      check("t7_ready_after", {31'd0, cmd_ready}, 1);
      send(1'b0, 2);
      check("t7_pulse_psen", {31'd0, psen}, 1);
      OPB_Rst = 1'b1;
      #1;
      check("t7_async_psen", {31'd0, psen}, 0);
      OPB_Rst = 1'b0;
      tick(2);

      check("dir_hold", dir_bad, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/adc5g_ps_sequencer.md
Name: adc5g_ps_sequencer

Overview:
- Sequences dynamic phase-shift commands to one ADC5G capture MMCM (PSEN/PSINCDEC/PSDONE) on behalf of the OPB controller registers.
- Accepts a direction-plus-step-count command, issues one PSEN pulse per step, waits for PSDONE with timeout, and tracks accumulated phase position.
- Reports busy, done and error status back to software.
- One instance per ADC; PSCLK of the MMCM is driven by OPB_Clk at top level.

Parameters:
- STEP_W, 10, width of the step-count field.
- POS_W, 16, width of the signed phase-position accumulator.
- TIMEOUT_CYCLES, 1024, OPB_Clk cycles allowed in WAIT before timeout (>=2).
- GAP_CYCLES, 2, idle cycles between PSDONE and the next PSEN (>=1).

Ports:
- OPB_Clk  in  1  sole clock; also feeds MMCM PSCLK at top level.
- OPB_Rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command can be accepted.
- cmd_dir  in  1  1 = increment, 0 = decrement.
- cmd_steps  in  STEP_W  number of steps to perform.
- clear_pos  in  1  synchronous clear of phase_pos.
- dcm_locked  in  1  MMCM lock status.
- psen  out  1  MMCM phase-shift enable.
- psincdec  out  1  MMCM phase-shift direction.
- psdone  in  1  MMCM phase-shift completion.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse at command end, success or error.
- steps_done  out  STEP_W  steps completed in current or last command.
- phase_pos  out  POS_W  signed accumulated position.
- err_timeout  out  1  sticky timeout flag.
- err_lock  out  1  sticky lock-loss abort flag.

Behaviour:
- Reset: state IDLE; all outputs 0 except cmd_ready, which follows dcm_locked.
- States and outputs:
  - States: IDLE, PULSE, WAIT, GAP, FIN.
  - psen = (state==PULSE). busy = (state!=IDLE).
  - done is registered and high for exactly one cycle after entering FIN.
- Accept:
  - cmd_ready = (state==IDLE) && dcm_locked.
  - On cmd_valid && cmd_ready: latch dir into psincdec and cmd_steps into remaining; clear steps_done, err_timeout and err_lock.
  - Next state is PULSE, or FIN if cmd_steps==0 (no psen is issued).
- psincdec holds the latched dir for the whole command and after it, until the next accept.
- PULSE: lasts exactly 1 cycle, then WAIT; the timeout counter is cleared.
- WAIT:
  - On psdone: steps_done+1; phase_pos ±1, wrapping mod 2^POS_W.
  - If remaining==1, go to FIN; else remaining-1 and go to GAP.
  - On timeout counter == TIMEOUT_CYCLES-1 with no psdone: set err_timeout and go to FIN.
  - psdone in the same cycle as expiry counts as success.
- GAP: stays for GAP_CYCLES cycles, then PULSE.
- FIN: 1 cycle, then IDLE.
- Lock loss: dcm_locked==0 in PULSE, WAIT or GAP sets err_lock and goes to FIN next edge. A psen already in PULSE still completes its single cycle.
- psdone outside WAIT is ignored and has no effect on counters.
- clear_pos has priority over a same-cycle psdone update: phase_pos=0.
- cmd_valid while busy is ignored; no queuing.
- OPB_Rst mid-command: immediate return to IDLE, psen deasserts asynchronously, phase_pos=0.
- Latency from accept to first psen: 1 cycle. Per step: 1 + psdone latency + GAP_CYCLES.

Test Plan:
- Locked, cmd dir=1 steps=3, psdone 12 cycles after each psen -> exactly 3 one-cycle psen pulses with ≥GAP_CYCLES between psdone and next psen; done pulse; steps_done=3; phase_pos=+3; psincdec=1 throughout.
- dir=0 steps=2 from phase_pos=0 -> phase_pos=0xFFFE; then dir=1 steps=2 -> 0x0000 (wrap).
- steps=0 -> no psen; done pulses 2 cycles after accept; steps_done=0; busy high for exactly those cycles.
- steps=5, psdone withheld on step 2 -> err_timeout set TIMEOUT_CYCLES cycles after the 2nd psen; done pulses; steps_done=1; cmd_ready returns; flag clears on next accept.
- dcm_locked drops during WAIT of step 1 of 4 -> err_lock=1, FIN then IDLE; cmd_ready=0 until lock returns; stray psdone afterwards leaves phase_pos unchanged.
- clear_pos coincident with psdone; OPB_Rst asserted mid-WAIT -> phase_pos=0 in both cases; after reset, psen=0 immediately and busy=0.
